pingpong_frame_buffer: RTL

Multi-channel ping-pong sample buffer; the parametrised successor to the single-channel input buffer in front of the FIR/FFT cores. Accepts channel-interleaved samples over a valid/ready handshake and fills one bank while the processing core reads the other through a random-access port. Banks are exchanged by an explicit frame-release handshake. Overflow and channel-sequence errors are reported as sticky flags.

---
 rtl/dsp_pkg.sv | 21 ++
 rtl/frame_bank_ram.sv | 70 +++++++
 rtl/pingpong_frame_buffer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// ============================================================================
//  Module   : dsp_pkg
//  Brief    : Shared DSP defaults and width-derivation helper.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package dsp_pkg;

    localparam int DATA_WIDTH_DEF = 12;

    // Never returns less than 1 so that single-entry fields still get a bit.
    function automatic int clog2_min1(input int n);
        int v;
        v = $clog2(n);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_bank_ram.sv
// ============================================================================
//  Module   : frame_bank_ram
//  Brief    : Two-bank sample store, one write port, one registered read port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module frame_bank_ram
    import dsp_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int CHANNELS   = 2,
    parameter  int BLOCK_SIZE = 256,
    localparam int CW         = clog2_min1(CHANNELS),
    localparam int AW         = $clog2(BLOCK_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic                  wbank_i,
    input  logic [CW-1:0]         wchan_i,
    input  logic [AW-1:0]         widx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic                  rbank_i,
    input  logic [CW-1:0]         rchan_i,
    input  logic [AW-1:0]         ridx_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 * CHANNELS * BLOCK_SIZE;
    localparam int RAW   = $clog2(DEPTH);

    // Linear packing keeps the array dense when CHANNELS is not a power of 2.
    function automatic logic [RAW-1:0] lin_addr(input logic b,
                                                 input logic [CW-1:0] c,
                                                 input logic [AW-1:0] i);
        int a;
        a = (int'(b) * CHANNELS + int'(c)) * BLOCK_SIZE + int'(i);
        return RAW'(a);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [RAW-1:0]        w_waddr;
    logic [RAW-1:0]        w_raddr;
    logic                  w_rchan_ok;

    assign w_waddr    = lin_addr(wbank_i, wchan_i, widx_i);
    assign w_raddr    = lin_addr(rbank_i, rchan_i, ridx_i);
    assign w_rchan_ok = (int'(rchan_i) < CHANNELS);
    assign rdata_o    = rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[w_waddr] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= w_rchan_ok ? mem[w_raddr] : '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pingpong_frame_buffer.sv
// ============================================================================
//  Module   : pingpong_frame_buffer
//  Brief    : Multi-channel ping-pong frame buffer with frame-release handoff.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pingpong_frame_buffer
    import dsp_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int CHANNELS   = 2,
    parameter  int BLOCK_SIZE = 256,
    localparam int CW         = clog2_min1(CHANNELS),
    localparam int AW         = $clog2(BLOCK_SIZE),
    localparam int FW         = $clog2(CHANNELS * BLOCK_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [CW-1:0]         in_chan_i,
    input  logic [DATA_WIDTH-1:0] in_sample_i,
    output logic                  frame_ready_o,
    input  logic                  frame_release_i,
    input  logic                  rd_en_i,
    input  logic [CW-1:0]         rd_chan_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [FW-1:0]         fill_level_o,
    output logic                  overflow_o,
    output logic                  seq_err_o,
    input  logic                  err_clear_i
);

    localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);

    logic [1:0]    bank_full_q, bank_full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [CW-1:0] exp_chan_q, exp_chan_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          ovf_q, ovf_d;
    logic          seq_q, seq_d;

    logic w_accept, w_mismatch, w_complete, w_release;

    assign in_ready_o    = !bank_full_q[wr_bank_q];
    assign frame_ready_o = bank_full_q[rd_bank_q];
    assign fill_level_o  = fill_q;
    assign overflow_o    = ovf_q;
    assign seq_err_o     = seq_q;

    assign w_accept   = in_valid_i && in_ready_o && (in_chan_i == exp_chan_q);
    assign w_mismatch = in_valid_i && in_ready_o && (in_chan_i != exp_chan_q);
    assign w_complete = w_accept && (exp_chan_q == LAST_CHAN) && (wr_idx_q == '1);
    assign w_release  = frame_release_i && frame_ready_o;

    always_comb begin
        bank_full_d = bank_full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        exp_chan_d  = exp_chan_q;
        wr_idx_d    = wr_idx_q;
        fill_d      = fill_q;

        // Completion and release never target the same bank, so both apply.
        if (w_release) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = !rd_bank_q;
        end

        if (w_accept) begin
            fill_d = fill_q + FW'(1);
            if (exp_chan_q == LAST_CHAN) begin
                exp_chan_d = '0;
                wr_idx_d   = wr_idx_q + AW'(1);
            end else begin
                exp_chan_d = exp_chan_q + CW'(1);
            end
        end

        if (w_complete) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = !wr_bank_q;
            exp_chan_d             = '0;
            wr_idx_d               = '0;
            fill_d                 = '0;
        end

        ovf_d = (err_clear_i ? 1'b0 : ovf_q) | (in_valid_i && !in_ready_o);
        seq_d = (err_clear_i ? 1'b0 : seq_q) | w_mismatch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full_q <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            exp_chan_q  <= '0;
            wr_idx_q    <= '0;
            fill_q      <= '0;
            ovf_q       <= 1'b0;
            seq_q       <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            exp_chan_q  <= exp_chan_d;
            wr_idx_q    <= wr_idx_d;
            fill_q      <= fill_d;
            ovf_q       <= ovf_d;
            seq_q       <= seq_d;
        end
    end

    frame_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHANNELS   (CHANNELS),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (w_accept),
        .wbank_i (wr_bank_q),
        .wchan_i (exp_chan_q),
        .widx_i  (wr_idx_q),
        .wdata_i (in_sample_i),
        .re_i    (rd_en_i),
        .rbank_i (rd_bank_q),
        .rchan_i (rd_chan_i),
        .ridx_i  (rd_addr_i),
        .rdata_o (rd_data_o)
    );

endmodule

`default_nettype wire
